// File: rtl/adc_frame_pkg.sv
// Shared types and constants for the ADC frame capture buffer.
package adc_frame_pkg;

  localparam int FRAME_LEN_DEF = 68;
  localparam int SAMPLE_W      = 8;

  localparam logic TRIG_RISE = 1'b0;
  localparam logic TRIG_FALL = 1'b1;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_WAIT_TRIG = 3'd1,
    ST_CAPTURE   = 3'd2,
    ST_PREFETCH  = 3'd3,
    ST_READOUT   = 3'd4
  } state_t;

endpackage

// File: rtl/adc_frame_buffer_sample_ram.sv
// Simple dual-port sample store: synchronous write, registered synchronous read.
// The read register has a synchronous clear so rd_data returns to 0 on reset/abort.
module sample_ram
  import adc_frame_pkg::*;
#(
  parameter int ADDR_W = 7
) (
  input  logic                clk,
  input  logic                we,
  input  logic [ADDR_W-1:0]   waddr,
  input  logic [SAMPLE_W-1:0] wdata,
  input  logic                re,
  input  logic [ADDR_W-1:0]   raddr,
  input  logic                clr,
  output logic [SAMPLE_W-1:0] rdata
);

  logic [SAMPLE_W-1:0] mem [0:(1<<ADDR_W)-1];

  // Write port.
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Registered read port with output-register clear.
  always_ff @(posedge clk) begin
    if (clr)     rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/adc_frame_buffer.sv
// Triggered single-frame ADC capture, served byte-by-byte to a downstream sender.
//
// state        | meaning
// -------------+-------------------------------------------------------------
// ST_IDLE      | waiting for arm; all outputs low
// ST_WAIT_TRIG | decimating samples, looking for the trigger edge (or force)
// ST_CAPTURE   | writing kept samples to addresses 1..FRAME_LEN-1
// ST_PREFETCH  | one cycle to read address 0 into the RAM output register
// ST_READOUT   | frame_ready high; rd_req steps through the frame
module adc_frame_buffer
  import adc_frame_pkg::*;
#(
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int ADDR_W    = 7
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [SAMPLE_W-1:0] adc_data,
  input  logic                adc_valid,
  input  logic                arm,
  input  logic                abort,
  input  logic                force_trig,
  input  logic [SAMPLE_W-1:0] trig_level,
  input  logic                trig_falling,
  input  logic [7:0]          decim,
  output logic                busy,
  output logic                frame_ready,
  input  logic                rd_req,
  output logic [SAMPLE_W-1:0] rd_data,
  output logic                rd_last,
  output logic                frame_done
);

  localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(FRAME_LEN - 1);

  state_t              state;
  logic [7:0]          decim_r;
  logic [7:0]          dcnt;
  logic [7:0]          dcnt_nxt;
  logic [SAMPLE_W-1:0] prev;
  logic                prev_valid;
  logic [ADDR_W-1:0]   wr_ptr;
  logic [ADDR_W-1:0]   rd_ptr;

  logic                kept;
  logic                edge_hit;
  logic                trig_hit;
  logic                ram_we;
  logic [ADDR_W-1:0]   ram_waddr;
  logic                ram_re;
  logic [ADDR_W-1:0]   ram_raddr;
  logic                ram_clr;

  // Decimation, trigger compare and RAM port steering.
  always_comb begin
    kept     = adc_valid && (dcnt == 8'd0);
    dcnt_nxt = (dcnt == decim_r) ? 8'd0 : dcnt + 8'd1;
    if (trig_falling == TRIG_FALL)
      edge_hit = prev_valid && (prev >= trig_level) && (adc_data < trig_level);
    else
      edge_hit = prev_valid && (prev < trig_level) && (adc_data >= trig_level);
    trig_hit  = kept && (force_trig || edge_hit);

    ram_we    = 1'b0;
    ram_waddr = '0;
    ram_re    = 1'b0;
    ram_raddr = rd_ptr + ADDR_W'(1);
    ram_clr   = rst || abort;
    if (!(rst || abort)) begin
      case (state)
        ST_WAIT_TRIG: if (trig_hit) ram_we = 1'b1;
        ST_CAPTURE: begin
          if (kept) begin
            ram_we    = 1'b1;
            ram_waddr = wr_ptr;
          end
        end
        ST_PREFETCH: begin
          ram_re    = 1'b1;
          ram_raddr = '0;
        end
        ST_READOUT: begin
          if (rd_req) begin
            if (!rd_last) ram_re  = 1'b1;
            else          ram_clr = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  sample_ram #(.ADDR_W(ADDR_W)) u_ram (
    .clk   (clk),
    .we    (ram_we),
    .waddr (ram_waddr),
    .wdata (adc_data),
    .re    (ram_re),
    .raddr (ram_raddr),
    .clr   (ram_clr),
    .rdata (rd_data)
  );

  // Control FSM with registered outputs; abort behaves like reset.
  always_ff @(posedge clk) begin
    if (rst || abort) begin
      state       <= ST_IDLE;
      busy        <= 1'b0;
      frame_ready <= 1'b0;
      rd_last     <= 1'b0;
      frame_done  <= 1'b0;
      decim_r     <= '0;
      dcnt        <= '0;
      prev        <= '0;
      prev_valid  <= 1'b0;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
    end else begin
      frame_done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (arm) begin
            decim_r    <= decim;
            dcnt       <= '0;
            prev_valid <= 1'b0;
            busy       <= 1'b1;
            state      <= ST_WAIT_TRIG;
          end
        end
        ST_WAIT_TRIG: begin
          if (adc_valid) dcnt <= dcnt_nxt;
          if (kept) begin
            prev       <= adc_data;
            prev_valid <= 1'b1;
          end
          if (trig_hit) begin
            wr_ptr <= ADDR_W'(1);
            state  <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (adc_valid) dcnt <= dcnt_nxt;
          if (kept) begin
            wr_ptr <= wr_ptr + ADDR_W'(1);
            if (wr_ptr == LAST_IDX) state <= ST_PREFETCH;
          end
        end
        ST_PREFETCH: begin
          rd_ptr      <= '0;
          rd_last     <= 1'b0;
          frame_ready <= 1'b1;
          state       <= ST_READOUT;
        end
        ST_READOUT: begin
          if (rd_req) begin
            if (!rd_last) begin
              rd_ptr  <= rd_ptr + ADDR_W'(1);
              rd_last <= ((rd_ptr + ADDR_W'(1)) == LAST_IDX);
            end else begin
              busy        <= 1'b0;
              frame_ready <= 1'b0;
              rd_last     <= 1'b0;
              frame_done  <= 1'b1;
              state       <= ST_IDLE;
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_adc_frame_buffer.sv
// Directed bench for adc_frame_buffer: ramp, decimation, falling trigger,
// abort/re-arm and arm collision, with hand-computed expected bytes.
module tb_adc_frame_buffer;

  localparam int FL = 68;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] adc_data;
  logic       adc_valid;
  logic       arm;
  logic       abort;
  logic       force_trig;
  logic [7:0] trig_level;
  logic       trig_falling;
  logic [7:0] decim;
  logic       busy;
  logic       frame_ready;
  logic       rd_req;
  logic [7:0] rd_data;
  logic       rd_last;
  logic       frame_done;

  int n_cmp = 0;
  int n_err = 0;

  adc_frame_buffer #(.FRAME_LEN(FL), .ADDR_W(7)) dut (
    .clk          (clk),
    .rst          (rst),
    .adc_data     (adc_data),
    .adc_valid    (adc_valid),
    .arm          (arm),
    .abort        (abort),
    .force_trig   (force_trig),
    .trig_level   (trig_level),
    .trig_falling (trig_falling),
    .decim        (decim),
    .busy         (busy),
    .frame_ready  (frame_ready),
    .rd_req       (rd_req),
    .rd_data      (rd_data),
    .rd_last      (rd_last),
    .frame_done   (frame_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"}, {31'd0, busy}, 0);
    chk({tag, "_ready"}, {31'd0, frame_ready}, 0);
    chk({tag, "_rd_data"}, {24'd0, rd_data}, 0);
    chk({tag, "_rd_last"}, {31'd0, rd_last}, 0);
    chk({tag, "_done"}, {31'd0, frame_done}, 0);
  endtask

  task automatic do_arm(input logic [7:0] d, input logic fall, input logic [7:0] lvl, input logic frc);
    decim        = d;
    trig_falling = fall;
    trig_level   = lvl;
    force_trig   = frc;
    arm          = 1'b1;
    @(negedge clk);
    arm       = 1'b0;
    adc_valid = 1'b0;
  endtask

  task automatic feed(input logic [7:0] start, input logic [7:0] step, input int n);
    logic [7:0] v;
    v = start;
    for (int i = 0; i < n; i++) begin
      adc_data  = v;
      adc_valid = 1'b1;
      @(negedge clk);
      v = v + step;
    end
    adc_valid = 1'b0;
  endtask

  // Called one negedge after the last capture write.
  task automatic expect_ready(input string tag);
    chk({tag, "_prefetch_ready"}, {31'd0, frame_ready}, 0);
    chk({tag, "_prefetch_busy"}, {31'd0, busy}, 1);
    @(negedge clk);
    chk({tag, "_ready"}, {31'd0, frame_ready}, 1);
  endtask

  task automatic readout(input string tag, input logic [7:0] b0, input logic [7:0] step, input bit gaps);
    logic [7:0] e;
    int         n_last;
    e      = b0;
    n_last = 0;
    for (int i = 0; i < FL; i++) begin
      chk($sformatf("%s_byte%0d", tag, i), {24'd0, rd_data}, {24'd0, e});
      chk($sformatf("%s_last%0d", tag, i), {31'd0, rd_last}, (i == FL-1) ? 1 : 0);
      if (frame_done) n_last++;
      if (rd_last) n_last = n_last + 0;
      rd_req = 1'b1;
      @(negedge clk);
      rd_req = 1'b0;
      if (gaps && i < FL-1) begin
        chk($sformatf("%s_hold%0d", tag, i+1), {24'd0, rd_data}, {24'd0, e + step});
        @(negedge clk);
      end
      e = e + step;
    end
    chk({tag, "_early_done"}, n_last, 0);
    chk({tag, "_done"}, {31'd0, frame_done}, 1);
    chk({tag, "_busy_after"}, {31'd0, busy}, 0);
    chk({tag, "_ready_after"}, {31'd0, frame_ready}, 0);
    chk({tag, "_last_after"}, {31'd0, rd_last}, 0);
    @(negedge clk);
    chk({tag, "_done_pulse"}, {31'd0, frame_done}, 0);
  endtask

  initial begin
    rst = 1'b1; adc_data = '0; adc_valid = 1'b0; arm = 1'b0; abort = 1'b0;
    force_trig = 1'b0; trig_level = '0; trig_falling = 1'b0; decim = '0; rd_req = 1'b0;
    repeat (3) @(negedge clk);
    chk_idle("reset");
    rst = 1'b0;
    @(negedge clk);

    // Ramp capture, rising edge at 0x80.
    do_arm(8'd0, 1'b0, 8'h80, 1'b0);
    chk("ramp_busy_armed", {31'd0, busy}, 1);
    feed(8'h70, 8'd1, 84);
    adc_data = 8'hEE; adc_valid = 1'b1;
    expect_ready("ramp");
    adc_valid = 1'b0;
    readout("ramp", 8'h80, 8'd1, 1'b0);

    // Decimation by 3 with forced trigger on the first kept sample.
    do_arm(8'd2, 1'b0, 8'h80, 1'b1);
    feed(8'h00, 8'd1, 202);
    expect_ready("decim");
    force_trig = 1'b0;
    readout("decim", 8'h00, 8'd3, 1'b1);

    // Falling edge trigger; reads spaced out to check rd_data holds.
    do_arm(8'd0, 1'b1, 8'h80, 1'b0);
    feed(8'h90, 8'd0, 2);
    feed(8'h7F, 8'hFF, FL);
    expect_ready("fall");
    readout("fall", 8'h7F, 8'hFF, 1'b1);

    // Abort after 30 writes, rd_req ignored, then re-arm for a fresh frame.
    do_arm(8'd0, 1'b0, 8'h80, 1'b1);
    feed(8'h20, 8'd1, 30);
    abort = 1'b1; adc_data = 8'h55; adc_valid = 1'b1;
    @(negedge clk);
    abort = 1'b0; adc_valid = 1'b0;
    chk_idle("abort");
    rd_req = 1'b1;
    repeat (3) @(negedge clk);
    rd_req = 1'b0;
    chk_idle("abort_rdreq");
    // First sample 0x85 is above the level but has no predecessor: must not trigger.
    do_arm(8'd0, 1'b0, 8'h80, 1'b0);
    feed(8'h85, 8'd0, 1);
    feed(8'h10, 8'd0, 1);
    feed(8'h90, 8'd1, FL);
    expect_ready("rearm");
    readout("rearm", 8'h90, 8'd1, 1'b0);

    // Arm collides with a valid 0xFF sample and force_trig.
    adc_data = 8'hFF; adc_valid = 1'b1;
    do_arm(8'd0, 1'b0, 8'h80, 1'b1);
    feed(8'h00, 8'd1, FL);
    expect_ready("coll");
    force_trig = 1'b0;
    chk("coll_byte0", {24'd0, rd_data}, 32'h00);
    rd_req = 1'b1;
    @(negedge clk);
    chk("coll_byte1", {24'd0, rd_data}, 32'h01);
    @(negedge clk);
    chk("coll_byte2", {24'd0, rd_data}, 32'h02);
    rd_req = 1'b0;
    abort  = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    chk_idle("abort_readout");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
